// File: rtl/wb_timer.sv
// Wishbone B3 classic timer: free-running up-counter, compare register, W1C pending flag, level irq.
// Define WB_TIMER_PRESCALE_EN to divide the counter tick by PRESCALE_DIV.
module wb_timer #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned PRESCALE_DIV = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        irq
);

    if (WIDTH < 1 || WIDTH > 32 || PRESCALE_DIV < 1) begin : g_param_check
        $error("wb_timer: WIDTH must be 1..32 and PRESCALE_DIV >= 1");
    end

    localparam logic [1:0] RegCount   = 2'd0;
    localparam logic [1:0] RegCompare = 2'd1;
    localparam logic [1:0] RegCtrl    = 2'd2;
    localparam logic [1:0] RegStatus  = 2'd3;

    // CTRL bit positions
    localparam int unsigned CtrlEn = 0;
    localparam int unsigned CtrlAr = 1;
    localparam int unsigned CtrlIe = 2;

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] compare_q, compare_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             irq_q, irq_d;

    logic             req;
    logic             wr_en;
    logic             rd_en;
    logic [1:0]       reg_sel;
    logic             count_wr;
    logic             tick_en;
    logic             tick;
    logic             match;
    logic [31:0]      rdata;
    logic [31:0]      count_merged;
    logic [31:0]      compare_merged;
    logic [31:0]      ctrl_merged;

    logic unused_inputs;
    assign unused_inputs = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

    assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_en   = req & wb_we_i;
    assign rd_en   = req & ~wb_we_i;
    assign reg_sel = wb_adr_i[3:2];

    assign count_merged   = merge_bytes(32'(count_q), wb_dat_i, wb_sel_i);
    assign compare_merged = merge_bytes(32'(compare_q), wb_dat_i, wb_sel_i);
    assign ctrl_merged    = merge_bytes({29'd0, ctrl_q}, wb_dat_i, wb_sel_i);

    assign count_wr = wr_en && (reg_sel == RegCount);

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_en && (reg_sel == RegCtrl)) begin
            ctrl_d = ctrl_merged[2:0];
        end
    end

    // Counting starts the cycle after EN is written to 1, but clearing EN stops it on the write edge.
    assign tick_en = ctrl_q[CtrlEn] & ctrl_d[CtrlEn];

`ifdef WB_TIMER_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(PRESCALE_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        presc_d = '0;
        if (tick_en && (presc_q != PrescLast)) begin
            presc_d = presc_q + 1'b1;
        end
    end

    assign tick = tick_en & (presc_q == PrescLast);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = tick_en;
`endif

    // A bus write to COUNT overrides the tick and suppresses that cycle's compare.
    assign match = tick & ~count_wr & (count_q == compare_q);

    always_comb begin
        count_d = count_q;
        if (count_wr) begin
            count_d = count_merged[WIDTH-1:0];
        end else if (tick) begin
            if (match && ctrl_q[CtrlAr]) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_comb begin
        compare_d = compare_q;
        if (wr_en && (reg_sel == RegCompare)) begin
            compare_d = compare_merged[WIDTH-1:0];
        end
    end

    // Set has priority over a simultaneous W1C.
    always_comb begin
        pending_d = pending_q;
        if (wr_en && (reg_sel == RegStatus) && wb_sel_i[0] && wb_dat_i[0]) begin
            pending_d = 1'b0;
        end
        if (match) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            RegCount:   rdata = 32'(count_q);
            RegCompare: rdata = 32'(compare_q);
            RegCtrl:    rdata = {29'd0, ctrl_q};
            RegStatus:  rdata = {31'd0, pending_q};
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        ack_d = req;
        dat_d = dat_q;
        if (rd_en) begin
            dat_d = rdata;
        end
        irq_d = pending_q & ctrl_q[CtrlIe];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            count_q   <= '0;
            compare_q <= '1;
            ctrl_q    <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ctrl_q    <= ctrl_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;
    assign irq      = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Scoreboard bench for wb_timer: expected read data is queued per transfer and checked on ack.
module tb_wb_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  adr = '0;
    logic [31:0] dat_w = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        rty;
    logic        irq;

    wb_timer #(
        .WIDTH       (32),
        .PRESCALE_DIV(4)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wb_adr_i(adr),
        .wb_dat_i(dat_w),
        .wb_sel_i(sel),
        .wb_we_i (we),
        .wb_cyc_i(cyc),
        .wb_stb_i(stb),
        .wb_cti_i(cti),
        .wb_bte_i(bte),
        .wb_dat_o(dat_r),
        .wb_ack_o(ack),
        .wb_err_o(err),
        .wb_rty_o(rty),
        .irq     (irq)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [31:0] exp;
        string       tag;
    } txn_t;

    txn_t sb_q[$];
    txn_t mon_t;
    int   n_checks = 0;
    int   n_errors = 0;
    logic ack_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack) begin
            check("ack_width", 32'(ack_prev), 32'd0);
            check("err_rty", {30'd0, err, rty}, 32'd0);
            if (sb_q.size() == 0) begin
                check("ack_unexpected", 32'd1, 32'd0);
            end else begin
                mon_t = sb_q.pop_front();
                if (mon_t.is_rd) check(mon_t.tag, dat_r, mon_t.exp);
            end
        end
        ack_prev <= ack;
    end

    task automatic push_txn(input logic is_rd, input logic [31:0] exp, input string tag);
        txn_t t;
        t.is_rd = is_rd;
        t.exp   = exp;
        t.tag   = tag;
        sb_q.push_back(t);
    endtask

    task automatic bus_xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] exp, input string tag);
        int n;
        push_txn(!w, exp, tag);
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 8);
        check({tag, "_lat"}, 32'(n), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bus_xfer(1'b1, a, d, s, 32'd0, "wr");
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        bus_xfer(1'b0, a, 32'd0, 4'h0, exp, tag);
    endtask

    task automatic wait_irq(input int expect_cycles, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!irq && n < 60);
        check(tag, 32'(n), 32'(expect_cycles));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_r, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;

        rd(4'h0, 32'h0000_0000, "rst_count");
        rd(4'h4, 32'hFFFF_FFFF, "rst_compare");
        rd(4'h8, 32'h0000_0000, "rst_ctrl");
        rd(4'hC, 32'h0000_0000, "rst_status");

        // Held strobe: acks on the 1st and 3rd edges only.
        push_txn(1'b1, 32'hFFFF_FFFF, "held_rd0");
        push_txn(1'b1, 32'hFFFF_FFFF, "held_rd1");
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'h4;
        repeat (4) @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;

        wr(4'h4, 32'h0000_0000, 4'hF);
        wr(4'h4, 32'h0000_AB00, 4'b0010);
        rd(4'h4, 32'h0000_AB00, "lane_compare");
        wr(4'h0, 32'hFFFF_FFFF, 4'h0);
        wr(4'h4, 32'hFFFF_FFFF, 4'h0);
        wr(4'h8, 32'hFFFF_FFFF, 4'h0);
        wr(4'hC, 32'hFFFF_FFFF, 4'h0);
        rd(4'h0, 32'h0000_0000, "sel0_count");
        rd(4'h4, 32'h0000_AB00, "sel0_compare");
        rd(4'h8, 32'h0000_0000, "sel0_ctrl");
        rd(4'hC, 32'h0000_0000, "sel0_status");

`ifdef WB_TIMER_PRESCALE_EN
        // Ticks every 4 cycles; match on the 3rd tick, irq one cycle later.
        wr(4'h4, 32'd2, 4'hF);
        wr(4'h8, 32'h7, 4'hF);
        wait_irq(13, "presc_irq_delay");
        rd(4'hC, 32'h1, "presc_status");
`else
        wr(4'h4, 32'd10, 4'hF);
        wr(4'h8, 32'h7, 4'hF);
        wait_irq(12, "irq_delay");
        rd(4'h0, 32'd2, "reload_count");
        wr(4'h8, 32'h4, 4'hF);
        rd(4'h0, 32'd4, "frozen_count");
        rd(4'hC, 32'h1, "pend_status");
        wr(4'hC, 32'h0, 4'hF);
        rd(4'hC, 32'h1, "w0_status");
        check("w0_irq", 32'(irq), 32'd1);
        wr(4'hC, 32'h1, 4'hF);
        check("w1c_irq_lag", 32'(irq), 32'd1);
        @(posedge clk);
        #1;
        check("w1c_irq_low", 32'(irq), 32'd0);
        rd(4'hC, 32'h0, "w1c_status");

        // Wrap without flag, then a non-reload match.
        wr(4'h8, 32'h0, 4'hF);
        wr(4'h0, 32'hFFFF_FFFE, 4'hF);
        wr(4'h8, 32'h1, 4'hF);
        wr(4'h4, 32'd5, 4'hF);
        rd(4'h0, 32'd1, "wrap_count");
        rd(4'hC, 32'h0, "wrap_status");
        @(posedge clk);
        #1;
        wr(4'h8, 32'h0, 4'hF);
        rd(4'h0, 32'd6, "match_count");
        rd(4'hC, 32'h1, "match_status");
`endif

        wr(4'h8, 32'h4, 4'hF);
        @(posedge clk);
        #1;
        check("pre_rst_irq", 32'(irq), 32'd1);

        // Reset lands during a read request.
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'h0; rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        rd(4'h0, 32'h0000_0000, "post_rst_count");
        rd(4'h4, 32'hFFFF_FFFF, "post_rst_compare");
        rd(4'h8, 32'h0000_0000, "post_rst_ctrl");
        rd(4'hC, 32'h0000_0000, "post_rst_status");

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
